// File: rtl/integ_thresh_mon_if.sv
// Signal bundle between the SPI-domain config/sample source and the
// integrating threshold monitor.
interface integ_thresh_mon_if #(
    parameter int SAMPLE_W = 16
);
    logic                       integ_en;
    logic [31:0]                integ_window;
    logic [14:0]                integ_thresh_avg;
    logic                       sample_valid;
    logic signed [SAMPLE_W-1:0] sample;
    logic                       running;
    logic                       window_done;
    logic                       over_thresh;
    logic                       cfg_err;

    modport master (
        output integ_en, integ_window, integ_thresh_avg, sample_valid, sample,
        input  running, window_done, over_thresh, cfg_err
    );

    modport slave (
        input  integ_en, integ_window, integ_thresh_avg, sample_valid, sample,
        output running, window_done, over_thresh, cfg_err
    );
endinterface

// File: rtl/integ_thresh_mon.sv
// Integrates |sample| over back-to-back windows of integ_window cycles and
// raises a sticky fault when a window's average exceeds the armed threshold.
module integ_thresh_mon #(
    parameter int SAMPLE_W = 16,
    parameter int ACC_W    = 48
) (
    input  logic              spi_clk,
    input  logic              spi_resetn,
    integ_thresh_mon_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INTEG = 2'd1,
        HALT  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [31:0]        win_q, win_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   limit_q, limit_d;
    logic               running_q, running_d;
    logic               done_q, done_d;
    logic               over_q, over_d;
    logic               cfg_err_q, cfg_err_d;
    logic [ACC_W-1:0]   acc_sum_s;

    // One extra bit keeps |most-negative| representable without overflow.
    function automatic logic [SAMPLE_W:0] abs_mag(input logic signed [SAMPLE_W-1:0] s);
        logic [SAMPLE_W:0] ext;
        ext = {s[SAMPLE_W-1], s};
        if (ext[SAMPLE_W]) begin
            abs_mag = ~ext + (SAMPLE_W+1)'(1);
        end else begin
            abs_mag = ext;
        end
    endfunction

    // State, counters, latched config and registered outputs.
    always_ff @(posedge spi_clk or negedge spi_resetn) begin
        if (!spi_resetn) begin
            state_q   <= IDLE;
            cnt_q     <= 32'd0;
            win_q     <= 32'd0;
            acc_q     <= {ACC_W{1'b0}};
            limit_q   <= {ACC_W{1'b0}};
            running_q <= 1'b0;
            done_q    <= 1'b0;
            over_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            win_q     <= win_d;
            acc_q     <= acc_d;
            limit_q   <= limit_d;
            running_q <= running_d;
            done_q    <= done_d;
            over_q    <= over_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Next-state, accumulation and window evaluation; a dropped enable overrides everything.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_d     = win_q;
        acc_d     = acc_q;
        limit_d   = limit_q;
        running_d = running_q;
        done_d    = 1'b0;
        over_d    = over_q;
        cfg_err_d = cfg_err_q;
        if (bus.sample_valid) begin
            acc_sum_s = acc_q + ACC_W'(abs_mag(bus.sample));
        end else begin
            acc_sum_s = acc_q;
        end

        if (!bus.integ_en) begin
            state_d   = IDLE;
            cnt_d     = 32'd0;
            acc_d     = {ACC_W{1'b0}};
            running_d = 1'b0;
            over_d    = 1'b0;
            cfg_err_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    win_d   = bus.integ_window;
                    cnt_d   = bus.integ_window;
                    acc_d   = {ACC_W{1'b0}};
                    limit_d = ACC_W'(bus.integ_thresh_avg) * ACC_W'(bus.integ_window);
                    if (bus.integ_window == 32'd0) begin
                        state_d   = HALT;
                        cfg_err_d = 1'b1;
                        running_d = 1'b0;
                    end else begin
                        state_d   = INTEG;
                        running_d = 1'b1;
                    end
                end
                INTEG: begin
                    // cnt==1 marks the last counted cycle; its sample is part of the result.
                    if (cnt_q == 32'd1) begin
                        done_d = 1'b1;
                        if (acc_sum_s > limit_q) begin
                            over_d = 1'b1;
                        end else begin
                            over_d = over_q;
                        end
                        acc_d = {ACC_W{1'b0}};
                        cnt_d = win_q;
                    end else begin
                        acc_d = acc_sum_s;
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                HALT: begin
                    running_d = 1'b0;
                end
                default: begin
                    state_d   = IDLE;
                    running_d = 1'b0;
                    acc_d     = {ACC_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.running     = running_q;
    assign bus.window_done = done_q;
    assign bus.over_thresh = over_q;
    assign bus.cfg_err     = cfg_err_q;
endmodule

// File: tb/tb_integ_thresh_mon.sv
// Directed plus randomized bench for integ_thresh_mon against a window-sum
// reference model that counts samples upward per window.
module tb_integ_thresh_mon;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    // Reference model state
    int     m_mode;     // 0 idle, 1 integrating, 2 halted
    longint m_pos;
    longint m_sum;
    longint m_win;
    longint m_lim;
    logic   e_run, e_done, e_over, e_cfg;

    integ_thresh_mon_if #(.SAMPLE_W(16)) bus ();

    integ_thresh_mon #(.SAMPLE_W(16), .ACC_W(48)) dut (
        .spi_clk    (clk),
        .spi_resetn (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_sum = 0; m_win = 0; m_lim = 0;
        e_run = 1'b0; e_done = 1'b0; e_over = 1'b0; e_cfg = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic [31:0] w, input logic [14:0] t,
                              input logic v, input logic signed [15:0] s);
        longint mag;
        mag = 0;
        if (v) mag = (s < 0) ? -longint'(s) : longint'(s);
        e_done = 1'b0;
        if (!en) begin
            m_mode = 0; m_sum = 0; m_pos = 0;
            e_run = 1'b0; e_over = 1'b0; e_cfg = 1'b0;
        end else if (m_mode == 0) begin
            m_win = longint'(w);
            m_lim = longint'(t) * longint'(w);
            m_pos = 0; m_sum = 0;
            if (w == 32'd0) begin
                m_mode = 2; e_cfg = 1'b1; e_run = 1'b0;
            end else begin
                m_mode = 1; e_run = 1'b1;
            end
        end else if (m_mode == 1) begin
            m_sum += mag;
            m_pos++;
            if (m_pos == m_win) begin
                e_done = 1'b1;
                if (m_sum > m_lim) e_over = 1'b1;
                m_sum = 0;
                m_pos = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".running"},     bus.running,     e_run);
        check({tag, ".window_done"}, bus.window_done, e_done);
        check({tag, ".over_thresh"}, bus.over_thresh, e_over);
        check({tag, ".cfg_err"},     bus.cfg_err,     e_cfg);
    endtask

    // Drive at the falling edge, let the DUT clock, compare 1 time unit later.
    task automatic cycle(input string tag, input logic en, input logic [31:0] w,
                         input logic [14:0] t, input logic v, input logic signed [15:0] s);
        bus.integ_en = en; bus.integ_window = w; bus.integ_thresh_avg = t;
        bus.sample_valid = v; bus.sample = s;
        @(posedge clk);
        model_step(en, w, t, v, s);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    initial begin
        int k;
        logic signed [15:0] s;
        n_cmp = 0; n_err = 0;
        model_reset();
        rst_n = 1'b0;
        bus.integ_en = 1'b0; bus.integ_window = 32'd0; bus.integ_thresh_avg = 15'd0;
        bus.sample_valid = 1'b0; bus.sample = 16'sd0;
        #12;
        check("reset.running", bus.running, 1'b0);
        check("reset.window_done", bus.window_done, 1'b0);
        check("reset.over_thresh", bus.over_thresh, 1'b0);
        check("reset.cfg_err", bus.cfg_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Exactly-at-limit average never trips
        for (int i = 0; i < 13; i++) cycle("eq_limit", 1'b1, 32'd4, 15'd100, 1'b1, 16'sd100);
        cycle("eq_abort", 1'b0, 32'd4, 15'd100, 1'b0, 16'sd0);

        // One sample of 101 trips the fault, which then sticks
        for (int i = 0; i < 14; i++)
            cycle("over1", 1'b1, 32'd4, 15'd100, 1'b1, (i == 2) ? 16'sd101 : 16'sd100);
        check("over1.sticky", bus.over_thresh, 1'b1);
        cycle("over1_clear", 1'b0, 32'd4, 15'd100, 1'b0, 16'sd0);
        check("over1.cleared", bus.over_thresh, 1'b0);

        // Negative samples count by magnitude
        for (int i = 0; i < 18; i++)
            cycle("abs", 1'b1, 32'd8, 15'd50, 1'b1, (i % 2 == 0) ? -16'sd200 : 16'sd0);
        cycle("abs_abort", 1'b0, 32'd8, 15'd50, 1'b0, 16'sd0);
        for (int i = 0; i < 4; i++) cycle("minneg", 1'b1, 32'd1, 15'd32767, 1'b1, 16'sh8000);
        check("minneg.over", bus.over_thresh, 1'b1);
        cycle("minneg_abort", 1'b0, 32'd1, 15'd0, 1'b0, 16'sd0);

        // Zero window halts with cfg_err
        for (int i = 0; i < 4; i++) cycle("win0", 1'b1, 32'd0, 15'd10, 1'b1, 16'sd500);
        check("win0.cfg_err", bus.cfg_err, 1'b1);
        cycle("win0_clear", 1'b0, 32'd0, 15'd10, 1'b0, 16'sd0);
        for (int i = 0; i < 7; i++) cycle("win3", 1'b1, 32'd3, 15'd10, 1'b1, 16'sd9);
        cycle("win3_abort", 1'b0, 32'd3, 15'd10, 1'b0, 16'sd0);

        // Partial window abort, re-arm, and mid-run config change ignored
        for (int i = 0; i < 6; i++) cycle("partial", 1'b1, 32'd10, 15'd1, 1'b1, 16'sd1000);
        cycle("partial_drop", 1'b0, 32'd2, 15'd1, 1'b1, 16'sd1000);
        for (int i = 0; i < 6; i++) cycle("rearm2", 1'b1, 32'd2, 15'd1, 1'b1, 16'sd1);
        for (int i = 0; i < 9; i++) cycle("cfgchg", 1'b1, 32'd5, 15'd0, 1'b1, 16'sd3);
        cycle("cfgchg_abort", 1'b0, 32'd5, 15'd0, 1'b0, 16'sd0);

        // Asynchronous reset mid-window with the fault set
        for (int i = 0; i < 6; i++) cycle("prereset", 1'b1, 32'd2, 15'd0, 1'b1, 16'sd5);
        check("prereset.over", bus.over_thresh, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        cycle("rearm5", 1'b1, 32'd5, 15'd0, 1'b1, 16'sd7);
        k = 0;
        while (k < 20) begin
            cycle("latency", 1'b1, 32'd5, 15'd0, 1'b1, 16'sd7);
            k++;
            if (bus.window_done === 1'b1) break;
        end
        n_cmp++;
        assert (k == 5) else begin
            n_err++;
            $error("FAIL first_done_latency observed=%0d expected=%0d", k, 5);
        end
        cycle("latency_abort", 1'b0, 32'd5, 15'd0, 1'b0, 16'sd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            s = 16'($urandom);
            if ($urandom_range(0, 9) == 0) s = 16'sh8000;
            cycle("random", ($urandom_range(0, 29) != 0),
                  32'($urandom_range(0, 6)), 15'($urandom_range(0, 32767)),
                  1'($urandom_range(0, 1)), s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
